// File: rtl/anc_stage_sequencer_pkg.sv
// anc_seq_pkg: shared types and helpers for the ANC stage sequencer.
// Holds the sequencer state encoding, default sizing constants and the
// saturating increment used by both event counters.
package anc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LP_WAIT,
    ERR_WAIT,
    LMS_WAIT,
    FIR_WAIT,
    OUT_WAIT
  } seq_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned DEFAULT_CNT_W   = 16;

  // Increment that sticks at 'limit' instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/anc_stage_sequencer_if.sv
// anc_stage_sequencer_if: sample strobe, stage start/done handshakes and
// status outputs of the ANC stage sequencer.
// Optional macro ANC_SEQ_PERF_EN adds the latency status signals.
interface anc_stage_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             sample_pulse_in;
  logic             adapt_en_in;
  logic             lp_amb_done_in;
  logic             lp_fb_done_in;
  logic             err_done_in;
  logic             lms_done_in;
  logic             fir_done_in;
  logic             out_done_in;
  logic             lp_start_out;
  logic             err_start_out;
  logic             lms_start_out;
  logic             fir_start_out;
  logic             out_start_out;
  logic             busy_out;
  logic             frame_done_out;
  logic             overrun_out;
  logic [CNT_W-1:0] overrun_cnt_out;
  logic [CNT_W-1:0] timeout_cnt_out;
`ifdef ANC_SEQ_PERF_EN
  logic [15:0]      last_lat_out;
  logic [15:0]      max_lat_out;
`endif

  // Sequencer side.
  modport master (
    input  sample_pulse_in, adapt_en_in,
    input  lp_amb_done_in, lp_fb_done_in, err_done_in,
    input  lms_done_in, fir_done_in, out_done_in,
    output lp_start_out, err_start_out, lms_start_out,
    output fir_start_out, out_start_out,
    output busy_out, frame_done_out, overrun_out,
    output overrun_cnt_out, timeout_cnt_out
`ifdef ANC_SEQ_PERF_EN
    , output last_lat_out, max_lat_out
`endif
  );

  // I2S receiver / filter-stage side.
  modport slave (
    output sample_pulse_in, adapt_en_in,
    output lp_amb_done_in, lp_fb_done_in, err_done_in,
    output lms_done_in, fir_done_in, out_done_in,
    input  lp_start_out, err_start_out, lms_start_out,
    input  fir_start_out, out_start_out,
    input  busy_out, frame_done_out, overrun_out,
    input  overrun_cnt_out, timeout_cnt_out
`ifdef ANC_SEQ_PERF_EN
    , input last_lat_out, max_lat_out
`endif
  );

endinterface

// File: rtl/anc_stage_sequencer_watchdog.sv
// seq_watchdog: per-stage cycle counter. Cleared by the sequencer on every
// state change and while idle; flags timeout once it has counted
// TIMEOUT_CYCLES-1 cycles, then holds.
module seq_watchdog
  import anc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_in,
  output logic timeout_out
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Count cycles in the current wait state, stopping at the limit.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || clear_in) begin
      count_q <= '0;
    end else if (count_q != LIMIT) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign timeout_out = (count_q == LIMIT);

endmodule

// File: rtl/anc_stage_sequencer.sv
// anc_stage_sequencer: per-sample controller for the ANC datapath.
// Turns each new-sample strobe into a chain of one-cycle stage starts
// (lowpass pair -> error -> NLMS (optional) -> FIR -> delay/scale), with a
// per-stage watchdog, overrun detection and saturating event counters.
// Optional macro ANC_SEQ_PERF_EN adds pass-latency status (last and max).
module anc_stage_sequencer
  import anc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  anc_stage_sequencer_if.master seq_bus
);

  localparam logic [31:0] CNT_MAX =
    (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  seq_state_t       state_q, state_d;
  logic             amb_q, amb_d, fb_q, fb_d;
  logic             amb_seen, fb_seen;
  logic             lp_start_q, lp_start_d;
  logic             err_start_q, err_start_d;
  logic             lms_start_q, lms_start_d;
  logic             fir_start_q, fir_start_d;
  logic             out_start_q, out_start_d;
  logic             frame_q, frame_d;
  logic             tmo_evt, ovr_evt;
  logic             ovr_q;
  logic [CNT_W-1:0] ovr_cnt_q, tmo_cnt_q;
  logic             wd_clear, wd_timeout;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clear_in   (wd_clear),
    .timeout_out(wd_timeout)
  );

  // Restart the watchdog whenever a new state is entered and while idle.
  assign wd_clear = (state_q == IDLE) || (state_d != state_q);

  // A sample arriving in any non-idle state is dropped and counted.
  assign ovr_evt = seq_bus.sample_pulse_in && (state_q != IDLE);

  // Next-state, stage-start and event decode.
  always_comb begin
    state_d     = state_q;
    amb_d       = amb_q;
    fb_d        = fb_q;
    amb_seen    = amb_q | seq_bus.lp_amb_done_in;
    fb_seen     = fb_q | seq_bus.lp_fb_done_in;
    lp_start_d  = 1'b0;
    err_start_d = 1'b0;
    lms_start_d = 1'b0;
    fir_start_d = 1'b0;
    out_start_d = 1'b0;
    frame_d     = 1'b0;
    tmo_evt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        amb_d = 1'b0;
        fb_d  = 1'b0;
        if (seq_bus.sample_pulse_in) begin
          state_d    = LP_WAIT;
          lp_start_d = 1'b1;
        end
      end
      LP_WAIT: begin
        // Include this cycle's dones so a same-cycle pair advances at once.
        if (amb_seen && fb_seen) begin
          state_d     = ERR_WAIT;
          err_start_d = 1'b1;
          amb_d       = 1'b0;
          fb_d        = 1'b0;
        end else if (wd_timeout) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
          amb_d   = 1'b0;
          fb_d    = 1'b0;
        end else begin
          amb_d = amb_seen;
          fb_d  = fb_seen;
        end
      end
      ERR_WAIT: begin
        if (seq_bus.err_done_in) begin
          if (seq_bus.adapt_en_in) begin
            state_d     = LMS_WAIT;
            lms_start_d = 1'b1;
          end else begin
            state_d     = FIR_WAIT;
            fir_start_d = 1'b1;
          end
        end else if (wd_timeout) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
        end
      end
      LMS_WAIT: begin
        if (seq_bus.lms_done_in) begin
          state_d     = FIR_WAIT;
          fir_start_d = 1'b1;
        end else if (wd_timeout) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
        end
      end
      FIR_WAIT: begin
        if (seq_bus.fir_done_in) begin
          state_d     = OUT_WAIT;
          out_start_d = 1'b1;
        end else if (wd_timeout) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
        end
      end
      OUT_WAIT: begin
        if (seq_bus.out_done_in) begin
          state_d = IDLE;
          frame_d = 1'b1;
        end else if (wd_timeout) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        amb_d   = 1'b0;
        fb_d    = 1'b0;
      end
    endcase
  end

  // State, registered start pulses, flags and event counters.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      amb_q       <= 1'b0;
      fb_q        <= 1'b0;
      lp_start_q  <= 1'b0;
      err_start_q <= 1'b0;
      lms_start_q <= 1'b0;
      fir_start_q <= 1'b0;
      out_start_q <= 1'b0;
      frame_q     <= 1'b0;
      ovr_q       <= 1'b0;
      ovr_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      amb_q       <= amb_d;
      fb_q        <= fb_d;
      lp_start_q  <= lp_start_d;
      err_start_q <= err_start_d;
      lms_start_q <= lms_start_d;
      fir_start_q <= fir_start_d;
      out_start_q <= out_start_d;
      frame_q     <= frame_d;
      if (ovr_evt) begin
        ovr_q     <= 1'b1;
        ovr_cnt_q <= CNT_W'(sat_inc(32'(ovr_cnt_q), CNT_MAX));
      end
      if (tmo_evt) begin
        tmo_cnt_q <= CNT_W'(sat_inc(32'(tmo_cnt_q), CNT_MAX));
      end
    end
  end

  assign seq_bus.lp_start_out    = lp_start_q;
  assign seq_bus.err_start_out   = err_start_q;
  assign seq_bus.lms_start_out   = lms_start_q;
  assign seq_bus.fir_start_out   = fir_start_q;
  assign seq_bus.out_start_out   = out_start_q;
  assign seq_bus.busy_out        = (state_q != IDLE);
  assign seq_bus.frame_done_out  = frame_q;
  assign seq_bus.overrun_out     = ovr_q;
  assign seq_bus.overrun_cnt_out = ovr_cnt_q;
  assign seq_bus.timeout_cnt_out = tmo_cnt_q;

`ifdef ANC_SEQ_PERF_EN
  localparam logic [31:0] LAT_MAX = 32'h0000_FFFF;

  logic [15:0] lat_q, lat_done, last_lat_q, max_lat_q;

  // Latency of a pass that completes on this edge, including its final cycle.
  assign lat_done = 16'(sat_inc(32'(lat_q), LAT_MAX));

  // Pass latency counter; published only for passes that finish normally.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      lat_q      <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
    end else begin
      if (state_q == IDLE) begin
        lat_q <= seq_bus.sample_pulse_in ? 16'd1 : 16'd0;
      end else begin
        lat_q <= lat_done;
      end
      if (frame_d) begin
        last_lat_q <= lat_done;
        if (lat_done > max_lat_q) begin
          max_lat_q <= lat_done;
        end
      end
    end
  end

  assign seq_bus.last_lat_out = last_lat_q;
  assign seq_bus.max_lat_out  = max_lat_q;
`endif

endmodule
